act_absmax_quant: RTL and testbench
===================================

Name: act_absmax_quant

Overview:
- Per-vector absmax activation quantizer, directly downstream of the RMS-norm stage.
- Accepts one normalized fixed-point vector of D elements and finds its absolute maximum.
- Scales every element to signed QW-bit integers in [-QMAX, QMAX], QMAX = 2^(QW-1)-1, for the ternary matmul unit.
- Emits the quantized vector plus the absmax scale, which the output dequant stage uses.

Parameters:
- D, 4: elements per vector; codebase builds set it from config_pkg; must be >= 2.
- W, 16: width of input fixed-point elements, signed two's complement.
- QW, 8: width of each quantized output element, signed.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- in_ready_o  out  1  block can accept a vector.
- in_valid_i  in  1  a_i holds a valid vector.
- a_i  in  D*W  input vector; element k occupies bits [k*W +: W].
- out_ready_i  in  1  downstream accepts result.
- out_valid_o  out  1  result_o and scale_o are valid.
- result_o  out  D*QW  quantized vector; element k occupies bits [k*QW +: QW].
- scale_o  out  W  absmax of the vector, unsigned, range 0..2^(W-1)-1.

Behaviour:
- Reset (rst_ni low, any time, including mid-operation):
  - state = IDLE; internal vector, absmax and index cleared.
  - Outputs: result_o = 0, scale_o = 0, out_valid_o = 0, in_ready_o = 1 once reset deasserts.
- States: IDLE, SCAN, SCALE, QUANT, SEND.
- IDLE:
  - in_ready_o = 1.
  - On a rising edge with in_valid_i = 1: copy a_i into an internal register, idx = 0, absmax = 0, go to SCAN.
  - Later changes on a_i have no effect on the result.
- SCAN:
  - One element per cycle: abs = |x[idx]|, absmax = max(absmax, abs).
  - The most negative input saturates: |-2^(W-1)| = 2^(W-1)-1.
  - After element D-1 (D cycles), go to SCALE.
- SCALE: one cycle. Register the divisor = absmax, half = absmax >> 1, idx = 0. Go to QUANT.
- QUANT:
  - One element per cycle, combinational divide.
  - If absmax == 0, q = 0.
  - Otherwise q = sign(x) * min(QMAX, floor((abs*QMAX + half) / absmax)). This is round-half-away-from-zero.
  - Intermediate product width is W+QW bits, unsigned.
  - Write q into the output register at idx. After D cycles, latch scale_o = absmax and go to SEND.
- SEND:
  - out_valid_o = 1; it stays high until a rising edge with out_ready_i = 1, then go to IDLE.
  - result_o and scale_o are stable throughout SEND and held unchanged after it until the next SEND.
- in_ready_o is 0 in every state except IDLE. in_valid_i outside IDLE is ignored. There is no accept-while-sending bypass.
- Latency: with the acceptance edge as edge 0, out_valid_o rises after edge 2D+1. For D = 4 that is edge 9.
- Minimum initiation interval is 2D+3 cycles with out_ready_i held high.
- out_valid_o and in_ready_o are never both 1.

Test Plan:
- Basic quantization, D=4, W=16, QW=8: a = [100, -50, 25, 0] -> result [127, -64, 32, 0], scale_o = 100. out_valid_o rises after edge 9; in_ready_o is low from edge 1 until the SEND handshake.
- All-zero vector: a = [0, 0, 0, 0] -> result all 0, scale_o = 0, no divide-by-zero X on outputs.
- Saturation and rounding: a = [-32768, 1, 16384, -16384] -> scale_o = 32767, result [-127, 0, 64, -64].
- Backpressure: hold out_ready_i = 0 for 5 cycles in SEND -> out_valid_o stays 1, result_o and scale_o are unchanged, in_ready_o stays 0, in_valid_i pulses are ignored. Raising out_ready_i returns to IDLE on the next edge.
- Input isolation and back-to-back vectors: change a_i at edge 1 after acceptance -> result matches the captured vector. A second vector offered with in_valid_i high continuously is accepted exactly 2D+3 edges after the first.
- Async reset mid-QUANT (rst_ni low between edges): outputs clear immediately to 0 and in_ready_o = 1 after release. The next vector [8, -8, 4, 2] yields [127, -127, 64, 32] with scale 8.

Source files
------------

// File: rtl/act_absmax_quant_if.sv
// Handshake bundle for the absmax activation quantizer: vector in, quantized vector + scale out.
interface act_absmax_quant_if #(
    parameter int D  = 4,
    parameter int W  = 16,
    parameter int QW = 8
);
    logic              in_ready_o;
    logic              in_valid_i;
    logic [D*W-1:0]    a_i;
    logic              out_ready_i;
    logic              out_valid_o;
    logic [D*QW-1:0]   result_o;
    logic [W-1:0]      scale_o;

    modport slave (
        output in_ready_o, out_valid_o, result_o, scale_o,
        input  in_valid_i, a_i, out_ready_i
    );

    modport master (
        input  in_ready_o, out_valid_o, result_o, scale_o,
        output in_valid_i, a_i, out_ready_i
    );
endinterface

// File: rtl/act_absmax_quant.sv
// Per-vector absmax quantizer: scans |x| for the max, then maps each element to
// round-half-away-from-zero signed QW-bit integers in [-QMAX, QMAX].
module act_absmax_quant #(
    parameter int D  = 4,
    parameter int W  = 16,
    parameter int QW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    act_absmax_quant_if.slave    bus
);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = W + QW;
    localparam logic [PW-1:0] QMAX_P = PW'((2 ** (QW - 1)) - 1);

    typedef enum logic [2:0] {IDLE, SCAN, SCALE, QUANT, SEND} state_e;

    state_e                 state_q;
    logic [D-1:0][W-1:0]    vec_q;
    logic [W-1:0]           absmax_q, div_q, half_q, scale_q;
    logic [IW-1:0]          idx_q;
    logic [D-1:0][QW-1:0]   qbuf_q, res_q;
    logic                   in_ready_q, out_valid_q;

    logic [W-1:0]           cur, abs_v;
    logic [PW-1:0]          prod, quot;
    logic [QW-1:0]          mag, q;
    logic [D-1:0][QW-1:0]   qbuf_d;
    logic                   last;

    always_comb begin
        cur  = vec_q[idx_q];
        last = (idx_q == IW'(D - 1));
        // The most negative code has no positive twin, so it saturates.
        if (cur == {1'b1, {(W-1){1'b0}}})
            abs_v = {1'b0, {(W-1){1'b1}}};
        else if (cur[W-1])
            abs_v = -cur;
        else
            abs_v = cur;
        prod = PW'(abs_v) * QMAX_P + PW'(half_q);
        // Divisor forced nonzero so an all-zero vector never produces X.
        quot = prod / ((div_q == '0) ? PW'(1) : PW'(div_q));
        mag  = (quot > QMAX_P) ? QMAX_P[QW-1:0] : quot[QW-1:0];
        if (div_q == '0)
            q = '0;
        else if (cur[W-1])
            q = -mag;
        else
            q = mag;
        qbuf_d        = qbuf_q;
        qbuf_d[idx_q] = q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            absmax_q    <= '0;
            div_q       <= '0;
            half_q      <= '0;
            scale_q     <= '0;
            idx_q       <= '0;
            qbuf_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        vec_q      <= bus.a_i;
                        idx_q      <= '0;
                        absmax_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (abs_v > absmax_q) absmax_q <= abs_v;
                    if (last) state_q <= SCALE;
                    else      idx_q   <= idx_q + 1'b1;
                end
                SCALE: begin
                    div_q   <= absmax_q;
                    half_q  <= absmax_q >> 1;
                    idx_q   <= '0;
                    state_q <= QUANT;
                end
                QUANT: begin
                    qbuf_q <= qbuf_d;
                    // Publish only a complete vector so result_o holds between sends.
                    if (last) begin
                        res_q       <= qbuf_d;
                        scale_q     <= div_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                SEND: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = res_q;
    assign bus.scale_o     = scale_q;
endmodule

// File: tb/tb_act_absmax_quant.sv
// Directed bench for act_absmax_quant with a scoreboard queue of expected results.
module tb_act_absmax_quant;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int QW = 8;

    typedef struct packed {
        logic [D*QW-1:0] res;
        logic [W-1:0]    sc;
    } exp_t;

    logic clk, rst_n;
    int   tests = 0, fails = 0;
    exp_t sb[$];

    act_absmax_quant_if #(.D(D), .W(W), .QW(QW)) bus ();
    act_absmax_quant #(.D(D), .W(W), .QW(QW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D*W-1:0] vec(input int e0, e1, e2, e3);
        logic [D*W-1:0] v;
        v = {W'(e3), W'(e2), W'(e1), W'(e0)};
        return v;
    endfunction

    function automatic logic [D*QW-1:0] qvec(input int e0, e1, e2, e3);
        logic [D*QW-1:0] v;
        v = {QW'(e3), QW'(e2), QW'(e1), QW'(e0)};
        return v;
    endfunction

    // Reference: q = floor((2*a*QMAX + m) / (2*m)), clamped, sign restored.
    function automatic exp_t model(input logic [D*W-1:0] v);
        exp_t   e;
        longint a[D];
        longint m, qq, qmax;
        logic signed [W-1:0] x;
        qmax = (1 << (QW - 1)) - 1;
        m = 0;
        for (int k = 0; k < D; k++) begin
            x = v[k*W +: W];
            a[k] = (x < 0) ? -longint'(x) : longint'(x);
            if (a[k] > (1 << (W - 1)) - 1) a[k] = (1 << (W - 1)) - 1;
            if (a[k] > m) m = a[k];
        end
        for (int k = 0; k < D; k++) begin
            x = v[k*W +: W];
            qq = (m == 0) ? 0 : (2 * a[k] * qmax + m) / (2 * m);
            if (qq > qmax) qq = qmax;
            if (x < 0) qq = -qq;
            e.res[k*QW +: QW] = QW'(qq);
        end
        e.sc = W'(m);
        return e;
    endfunction

    task automatic push(input logic [D*QW-1:0] r, input int s);
        exp_t e;
        e.res = r;
        e.sc  = W'(s);
        sb.push_back(e);
    endtask

    // Drives a vector until accepted; returns #1 after the acceptance edge.
    task automatic send_vec(input logic [D*W-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        bus.a_i = v;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, 64'(bus.result_o), 64'(e.res));
            chk({tag, "_scale"}, 64'(bus.scale_o), 64'(e.sc));
        end
    endtask

    task automatic recv(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({tag, "_out_timeout"}, 64'd1, 64'd0);
        end else begin
            compare_head(tag);
            bus.out_ready_i = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready_i = 1'b0;
            chk({tag, "_idle_after"}, 64'({bus.out_valid_o, bus.in_ready_o}), 64'b01);
        end
    endtask

    initial begin
        logic [D*QW-1:0] held_res;
        logic [W-1:0]    held_sc;
        logic [D*W-1:0]  rv;
        int              acc2;

        rst_n = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.out_ready_i = 1'b0;
        #12;
        chk("reset_out", 64'({bus.out_valid_o, bus.scale_o, bus.result_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Basic vector with latency and in_ready profile.
        push(qvec(127, -64, 32, 0), 100);
        send_vec(vec(100, -50, 25, 0));
        chk("basic_in_ready_e1", 64'(bus.in_ready_o), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("basic_valid_e8", 64'(bus.out_valid_o), 64'd0);
        @(posedge clk);
        #1;
        chk("basic_valid_e9", 64'({bus.out_valid_o, bus.in_ready_o}), 64'b10);
        recv("basic");

        push(qvec(0, 0, 0, 0), 0);
        send_vec(vec(0, 0, 0, 0));
        recv("zero");

        push(qvec(-127, 0, 64, -64), 32767);
        send_vec(vec(-32768, 1, 16384, -16384));
        recv("sat");

        // Backpressure: hold SEND for 5 cycles while pulsing in_valid.
        push(qvec(127, -64, 32, 0), 100);
        send_vec(vec(100, -50, 25, 0));
        repeat (9) @(posedge clk);
        #1;
        held_res = bus.result_o;
        held_sc  = bus.scale_o;
        compare_head("bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.a_i = vec(1, 2, 3, 4);
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            chk("bp_hold", 64'({bus.out_valid_o, bus.in_ready_o}), 64'b10);
            chk("bp_stable", 64'({bus.scale_o, bus.result_o}), 64'({held_sc, held_res}));
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        chk("bp_release", 64'({bus.out_valid_o, bus.in_ready_o}), 64'b01);
        chk("bp_held_after", 64'({bus.scale_o, bus.result_o}), 64'({held_sc, held_res}));

        // Isolation + back-to-back: a_i changes after acceptance, in_valid stays high.
        push(qvec(-127, 64, 1, 0), 1000);
        push(qvec(127, 127, -127, 64), 12);
        @(negedge clk);
        bus.a_i = vec(-1000, 500, 4, 0);
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.a_i = vec(12, 12, -12, 6);
        acc2 = -1;
        for (int k = 1; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid_o) compare_head("iso");
            if (bus.in_ready_o) begin
                acc2 = k;
                break;
            end
        end
        chk("b2b_accept_edge", 64'(acc2), 64'(2 * D + 3));
        @(posedge clk);
        #1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        recv("b2b");

        // A few randomized vectors checked against the reference model.
        for (int i = 0; i < 3; i++) begin
            rv = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            sb.push_back(model(rv));
            send_vec(rv);
            recv("rand");
        end

        // Async reset in the middle of QUANT.
        send_vec(vec(300, -7, 9, 1));
        repeat (D + 3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 64'({bus.out_valid_o, bus.scale_o, bus.result_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", 64'(bus.in_ready_o), 64'd1);
        push(qvec(127, -127, 64, 32), 8);
        send_vec(vec(8, -8, 4, 2));
        recv("post_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
